// File: rtl/modn_down_counter.sv
// Mod-N down counter/timer: counts modulus-1 down to 0, then emits a one-cycle tc pulse.
// Auto-reload or one-shot; the modulus can be replaced at runtime with load.
module modn_down_counter #(
  parameter int WIDTH = 4,
  parameter int N     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  typedef enum logic {RUN, HALT} state_t;

  // A modulus of 2^WIDTH is stored as 0, so modulus-1 wraps to all-ones naturally.
  localparam logic [WIDTH-1:0] RST_MOD   = WIDTH'(N);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mod_reg, mod_nxt, count_nxt;
  logic             tc_nxt, done_nxt;
  logic             expire;

  assign expire = (state == RUN) && en && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mod_reg <= RST_MOD;
      count   <= RST_COUNT;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mod_reg <= mod_nxt;
      count   <= count_nxt;
      tc      <= tc_nxt;
      done    <= done_nxt;
    end
  end

  // Only load leaves HALT; one_shot is looked at solely on the expiry edge.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = RUN;
    end else if (expire && one_shot) begin
      state_nxt = HALT;
    end
  end

  always_comb begin
    mod_nxt   = mod_reg;
    count_nxt = count;
    tc_nxt    = 1'b0;
    done_nxt  = done;
    if (load) begin
      mod_nxt   = load_val;
      count_nxt = load_val - ONE;
      done_nxt  = 1'b0;
    end else if (state == RUN && en) begin
      if (count != '0) begin
        count_nxt = count - ONE;
      end else begin
        tc_nxt = 1'b1;
        if (one_shot) begin
          done_nxt = 1'b1;
        end else begin
          count_nxt = mod_reg - ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_modn_down_counter.sv
// Bench for modn_down_counter: hand-written vector table and corner sequences,
// then randomized traffic checked against an integer-arithmetic reference model.
module tb_modn_down_counter;

  localparam int W = 4;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         one_shot = 1'b0;
  logic [W-1:0] count;
  logic         tc;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state in plain integers: modulus 1..2^W, remaining count.
  int m_mod, m_cnt;
  bit m_tc, m_done, m_halt;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic         os;
    logic [W-1:0] c;
    logic         t;
    logic         d;
  } vec_t;

  vec_t vecs[$];

  modn_down_counter #(.WIDTH(W), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .one_shot (one_shot),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(logic ld, int lv, logic e, logic os, int c, logic t, logic d);
    vec_t v;
    v.ld = ld; v.lv = W'(lv); v.en = e; v.os = os; v.c = W'(c); v.t = t; v.d = d;
    return v;
  endfunction

  task automatic model_reset();
    m_mod = N; m_cnt = N - 1; m_tc = 0; m_done = 0; m_halt = 0;
  endtask

  task automatic model_step(input bit ld, input int lv, input bit e, input bit os);
    if (ld) begin
      m_mod = (lv == 0) ? (1 << W) : lv;
      m_cnt = m_mod - 1; m_done = 0; m_tc = 0; m_halt = 0;
    end else if (!m_halt && e) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1; m_tc = 0;
      end else begin
        m_tc = 1;
        if (os) begin m_halt = 1; m_done = 1; end
        else m_cnt = m_mod - 1;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic check_output(input string name, input logic [W-1:0] ec, input logic et, input logic ed);
    n_checks++;
    if (count !== ec) begin
      n_fail++;
      $display("[TB] FAIL %s count: got %0d, expected %0d", name, count, ec);
    end
    n_checks++;
    if (tc !== et) begin
      n_fail++;
      $display("[TB] FAIL %s tc: got %b, expected %b", name, tc, et);
    end
    n_checks++;
    if (done !== ed) begin
      n_fail++;
      $display("[TB] FAIL %s done: got %b, expected %b", name, done, ed);
    end
  endtask

  // Drive inputs away from the edge, take one rising edge, then sample 1ns later.
  task automatic apply_stimulus(input logic ld, input logic [W-1:0] lv, input logic e, input logic os);
    load = ld; load_val = lv; en = e; one_shot = os;
    @(posedge clk);
    model_step(ld, int'(lv), e, os);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load = 1'b0; en = 1'b0; one_shot = 1'b0; load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state", W'(N - 1), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    $display("[TB] start");
    model_reset();

    // Load mid-count, en gating at 0, one-shot halt, modulus 2^W and modulus 1.
    vecs.push_back(mk(0, 0, 1, 0, 8, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 7, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 6, 0, 0));
    vecs.push_back(mk(1, 3, 1, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 1, 0));
    vecs.push_back(mk(1, 5, 1, 1, 4, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 5, 0, 0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 15, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));

    // Free-running auto-reload from reset: tc once every N edges, with count back at N-1.
    do_reset();
    for (int k = 1; k <= 2 * N; k++) begin
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output($sformatf("autoreload_k%0d", k), W'(((N - 1 - k) % N + N) % N), (k % N) == 0, 1'b0);
    end

    do_reset();
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].os);
      check_output($sformatf("vec%0d", i), vecs[i].c, vecs[i].t, vecs[i].d);
    end

    // Modulus 2^W: full 16-cycle period.
    apply_stimulus(1'b1, '0, 1'b0, 1'b0);
    check_output("mod16_load", W'(15), 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output($sformatf("mod16_k%0d", k), W'((15 - k + 16) % 16), k == 16, 1'b0);
    end

    // Async reset at count=4, checked before the next edge.
    do_reset();
    repeat (5) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("pre_reset_cnt4", W'(4), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_output("async_reset_mid", W'(N - 1), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("resume_after_reset", W'(N - 2), 1'b0, 1'b0);

    // Async reset while halted.
    apply_stimulus(1'b1, W'(1), 1'b0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    check_output("halt_entry", W'(0), 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_output("async_reset_halt", W'(N - 1), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("resume_after_halt_reset", W'(N - 2), 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic         r_ld, r_en, r_os;
      logic [W-1:0] r_lv;
      r_ld = ($urandom_range(0, 15) == 0);
      r_lv = W'($urandom_range(0, (1 << W) - 1));
      r_en = ($urandom_range(0, 3) != 0);
      r_os = (k % 150 < 75) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      apply_stimulus(r_ld, r_lv, r_en, r_os);
      check_output($sformatf("rand%0d", k), W'(m_cnt), m_tc, m_done);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
